top_memory: RTL and testbench

TOP_MEMORY -- requirements
Module: top_memory

---
 rtl/top_memory.sv | 160 ++++++++++++++++
 tb/tb_top_memory.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/top_memory.sv
// Memory stage: drives the data bus for loads/stores through an IDLE/BUSY handshake
// and latches the memory->writeback pipeline registers.
module top_memory #(
  parameter int XLEN          = 32,
  parameter int OPLEN         = 10,
  parameter int USE_LOAD_BIT  = 0,
  parameter int USE_STORE_BIT = 1,
  parameter int FUNCT3_BIT_L  = 2,
  parameter int FUNCT3_BIT_M  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_memory,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [XLEN-1:0]  rs2data_em,
  input  logic             jump_state_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  rddata_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic             jump_state_mw,
  output logic             misalign_mw,
  output logic             stall_memory
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [OPLEN-1:0] r_op;
  logic [4:0]       r_rdsel;
  logic [XLEN-1:0]  r_rddata;
  logic [XLEN-1:0]  r_next_pc;
  logic             r_jump;
  logic             r_misalign;

  logic             w_load;
  logic             w_store;
  logic             w_memop;
  logic [2:0]       w_funct3;
  logic             w_mis_raw;
  logic             w_misaligned;
  logic             w_busy;
  logic             w_start;
  logic             w_stall;
  logic             w_update;
  logic [3:0]       w_be;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_load_data;

  assign w_load       = decoded_op_em[USE_LOAD_BIT];
  assign w_store      = decoded_op_em[USE_STORE_BIT];
  assign w_memop      = w_load | w_store;
  assign w_funct3     = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
  assign w_misaligned = w_memop & w_mis_raw;
  assign w_busy       = (r_state == S_BUSY);
  assign w_start      = phase_memory & w_memop & ~w_misaligned;
  assign w_stall      = w_start & ~(w_busy & dmem_ack);
  assign w_update     = phase_memory & ~w_stall;
  assign w_shifted    = dmem_rdata >> {alu_out_em[1:0], 3'b000};

  // Alignment check by access size (funct3[1:0]: byte/half/word)
  always_comb begin
    w_mis_raw = 1'b0;
    case (w_funct3[1:0])
      2'b00:   w_mis_raw = 1'b0;
      2'b01:   w_mis_raw = alu_out_em[0];
      2'b10:   w_mis_raw = (alu_out_em[1:0] != 2'b00);
      default: w_mis_raw = 1'b0;
    endcase
  end

  // Store byte enables and lane-replicated write data; loads present no enables
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = rs2data_em;
    case (w_funct3[1:0])
      2'b00:   w_wdata = {(XLEN/8){rs2data_em[7:0]}};
      2'b01:   w_wdata = {(XLEN/16){rs2data_em[15:0]}};
      default: w_wdata = rs2data_em;
    endcase
    if (w_busy && w_store) begin
      case (w_funct3[1:0])
        2'b00:   w_be = 4'b0001 << alu_out_em[1:0];
        2'b01:   w_be = 4'b0011 << alu_out_em[1:0];
        default: w_be = 4'b1111;
      endcase
    end else begin
      w_be = 4'b0000;
    end
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    w_load_data = dmem_rdata;
    case (w_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Bus handshake FSM; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_start ? S_BUSY : S_IDLE;
        S_BUSY:  r_state <= dmem_ack ? S_IDLE : S_BUSY;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory->writeback pipeline registers, advanced only when the stage completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_rdsel    <= 5'd0;
      r_rddata   <= '0;
      r_next_pc  <= '0;
      r_jump     <= 1'b0;
      r_misalign <= 1'b0;
    end else if (w_update) begin
      r_op       <= decoded_op_em;
      r_rdsel    <= rdsel_em;
      r_rddata   <= (w_load && !w_misaligned) ? w_load_data : alu_out_em;
      r_next_pc  <= next_pc_em;
      r_jump     <= jump_state_em;
      r_misalign <= w_misaligned;
    end
  end

  assign dmem_req      = w_busy;
  assign dmem_we       = w_busy & w_store;
  assign dmem_addr     = {alu_out_em[XLEN-1:2], 2'b00};
  assign dmem_be       = w_be;
  assign dmem_wdata    = w_wdata;
  assign stall_memory  = w_stall;
  assign decoded_op_mw = r_op;
  assign rdsel_mw      = r_rdsel;
  assign rddata_mw     = r_rddata;
  assign next_pc_mw    = r_next_pc;
  assign jump_state_mw = r_jump;
  assign misalign_mw   = r_misalign;

endmodule

// File: tb/tb_top_memory.sv
// Directed bench for top_memory: expected writeback results queued at issue,
// compared when the stage completes.
module tb_top_memory;
  localparam int XLEN  = 32;
  localparam int OPLEN = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             phase_memory;
  logic [OPLEN-1:0] decoded_op_em;
  logic [XLEN-1:0]  rs2data_em;
  logic             jump_state_em;
  logic [4:0]       rdsel_em;
  logic [XLEN-1:0]  next_pc_em;
  logic [XLEN-1:0]  alu_out_em;
  logic             dmem_req;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [3:0]       dmem_be;
  logic [XLEN-1:0]  dmem_wdata;
  logic             dmem_ack;
  logic [XLEN-1:0]  dmem_rdata;
  logic [OPLEN-1:0] decoded_op_mw;
  logic [4:0]       rdsel_mw;
  logic [XLEN-1:0]  rddata_mw;
  logic [XLEN-1:0]  next_pc_mw;
  logic             jump_state_mw;
  logic             misalign_mw;
  logic             stall_memory;

  typedef struct packed {
    logic [OPLEN-1:0] op;
    logic [4:0]       rd;
    logic [XLEN-1:0]  npc;
    logic             jump;
    logic [XLEN-1:0]  rddata;
    logic             mis;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   op_idx   = 0;

  always #5 clk = ~clk;

  top_memory dut (
    .clk(clk), .rst_n(rst_n), .phase_memory(phase_memory),
    .decoded_op_em(decoded_op_em), .rs2data_em(rs2data_em),
    .jump_state_em(jump_state_em), .rdsel_em(rdsel_em),
    .next_pc_em(next_pc_em), .alu_out_em(alu_out_em),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .decoded_op_mw(decoded_op_mw),
    .rdsel_mw(rdsel_mw), .rddata_mw(rddata_mw), .next_pc_mw(next_pc_mw),
    .jump_state_mw(jump_state_mw), .misalign_mw(misalign_mw),
    .stall_memory(stall_memory)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OPLEN-1:0] mk_op(input logic ld, input logic st, input logic [2:0] f3);
    return {5'b10101, f3, st, ld};
  endfunction

  // Issue one op, handshake the bus, and compare bus fields, stall count and latched results
  task automatic run_op(input string tag, input logic [OPLEN-1:0] op, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int ack_delay,
                        input int exp_stall, input logic exp_req, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_we,
                        input logic [31:0] exp_rd, input logic exp_mis);
    int   stalls = 0;
    int   busy_n = 0;
    bit   done   = 1'b0;
    logic saw_req = 1'b0;
    exp_t e;
    exp_t got;
    e.op = op; e.rd = 5'(op_idx + 1); e.npc = 32'h1000 + 32'(op_idx * 4);
    e.jump = op_idx[0]; e.rddata = exp_rd; e.mis = exp_mis;
    sb_q.push_back(e);
    @(negedge clk);
    decoded_op_em = op; alu_out_em = addr; rs2data_em = rs2;
    rdsel_em = e.rd; next_pc_em = e.npc; jump_state_em = e.jump;
    dmem_rdata = rdata; phase_memory = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      dmem_ack = (dmem_req && busy_n == ack_delay) ? 1'b1 : 1'b0;
      #1;
      if (dmem_req) begin
        if (!saw_req) begin
          check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
          check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
          check({tag, "_wdata"}, dmem_wdata, exp_wdata);
          check({tag, "_we"}, 32'(dmem_we), 32'(exp_we));
        end
        saw_req = 1'b1;
        busy_n++;
      end
      if (stall_memory) stalls++;
      else done = 1'b1;
      if (!done) @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, "_req_seen"}, 32'(saw_req), 32'(exp_req));
    @(posedge clk);
    #1;
    phase_memory = 1'b0;
    dmem_ack = 1'b0;
    got = '{op: decoded_op_mw, rd: rdsel_mw, npc: next_pc_mw, jump: jump_state_mw,
            rddata: rddata_mw, mis: misalign_mw};
    e = sb_q.pop_front();
    check({tag, "_rddata"}, got.rddata, e.rddata);
    check({tag, "_mis"}, 32'(got.mis), 32'(e.mis));
    check({tag, "_meta"}, {got.op, got.rd, got.npc[15:0], got.jump}, {e.op, e.rd, e.npc[15:0], e.jump});
    #1;
    check({tag, "_req_after"}, 32'(dmem_req), 32'd0);
    op_idx++;
  endtask

  initial begin
    rst_n = 1'b0; phase_memory = 1'b0; decoded_op_em = '0; rs2data_em = '0;
    jump_state_em = 1'b0; rdsel_em = 5'd0; next_pc_em = '0; alu_out_em = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_rddata", rddata_mw, 32'd0);
    check("rst_mis", 32'(misalign_mw), 32'd0);
    check("rst_stall", 32'(stall_memory), 32'd0);
    rst_n = 1'b1;

    run_op("alu",  mk_op(1'b0, 1'b0, 3'b000), 32'h1234, 32'h0, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h1234, 1'b0);
    run_op("lb",   mk_op(1'b1, 1'b0, 3'b000), 32'h103, 32'h0, 32'h80FF_FFFF, 3, 4, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0);
    run_op("sh",   mk_op(1'b0, 1'b1, 3'b001), 32'h202, 32'h0000_ABCD, 32'h0, 0, 1, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h202, 1'b0);
    run_op("lwmis", mk_op(1'b1, 1'b0, 3'b010), 32'h101, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h101, 1'b1);
    run_op("lhu",  mk_op(1'b1, 1'b0, 3'b101), 32'h2, 32'h0, 32'hFFFF_0000, 0, 1, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0000_FFFF, 1'b0);
    run_op("sb",   mk_op(1'b0, 1'b1, 3'b000), 32'h1, 32'h1234_5678, 32'h0, 1, 2, 1'b1, 4'b0010, 32'h7878_7878, 1'b1, 32'h1, 1'b0);
    run_op("sw",   mk_op(1'b0, 1'b1, 3'b010), 32'h300, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h300, 1'b0);
    run_op("lh",   mk_op(1'b1, 1'b0, 3'b001), 32'h6, 32'h0, 32'h8001_0000, 0, 1, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hFFFF_8001, 1'b0);
    run_op("lbu",  mk_op(1'b1, 1'b0, 3'b100), 32'h5, 32'h0, 32'h0000_9A00, 0, 1, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0000_009A, 1'b0);
    run_op("shmis", mk_op(1'b0, 1'b1, 3'b001), 32'h205, 32'h1111, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h205, 1'b1);
    run_op("lw",   mk_op(1'b1, 1'b0, 3'b010), 32'h8, 32'h0, 32'hCAFE_F00D, 2, 3, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);
    run_op("sbhi", mk_op(1'b0, 1'b1, 3'b000), 32'h403, 32'h0000_00A5, 32'h0, 0, 1, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b1, 32'h403, 1'b0);

    // Ack in IDLE must not start anything
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    check("idle_ack_req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    // Reset during BUSY, late ack ignored
    decoded_op_em = mk_op(1'b0, 1'b1, 3'b010); alu_out_em = 32'h100; rs2data_em = 32'h5555_AAAA;
    phase_memory = 1'b1;
    @(negedge clk);
    check("rstbusy_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstbusy_req", 32'(dmem_req), 32'd0);
    check("rstbusy_be", 32'(dmem_be), 32'd0);
    check("rstbusy_rddata", rddata_mw, 32'd0);
    check("rstbusy_meta", {22'd0, decoded_op_mw}, 32'd0);
    check("rstbusy_npc", next_pc_mw, 32'd0);
    phase_memory = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clk);
    check("rstbusy_ack_ignored", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rstbusy_idle", 32'(dmem_req), 32'd0);
    check("rstbusy_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
